// File: rtl/axi_read_burst_sequencer.sv
// AXI4 INCR read burst walker: one single-beat memory request per beat, one burst in flight.
// Latency: AR->mem_req 1 cycle, mem_ack->rvalid 1 cycle; an R beat held on rvalid stalls the walk until rready.
module axi_read_burst_sequencer #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 64,
   parameter int                ID_W     = 4,
   parameter logic [ADDR_W-1:0] MAX_ADDR = 'hFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              arvalid,
   output logic              arready,
   input  logic [ADDR_W-1:0] araddr,
   input  logic [7:0]        arlen,
   input  logic [2:0]        arsize,
   input  logic [ID_W-1:0]   arid,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [2:0]        mem_size,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rvalid,
   input  logic              rready,
   output logic [DATA_W-1:0] rdata,
   output logic [1:0]        rresp,
   output logic              rlast,
   output logic [ID_W-1:0]   rid,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP, ERR} state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W-1:0] next_addr;
   logic [7:0]        len;
   logic [7:0]        beat_cnt;
   logic [2:0]        size;
   logic              sticky_err;
   logic              next_err;
   logic              size_ok;
   logic              ar_hs;
   logic              r_hs;
   logic              ar_err;
   logic              last_beat;

   assign arready   = (state == IDLE);
   assign busy      = (state != IDLE);
   assign mem_req   = (state == ISSUE);
   assign mem_addr  = cur_addr;
   assign mem_size  = size;

   assign ar_hs     = arvalid & arready;
   assign r_hs      = rvalid & rready;
   assign ar_err    = (arsize > 3'd3) | (araddr > MAX_ADDR);
   assign last_beat = (beat_cnt == len);

   // An illegal size never moves the address; its beats are already sticky errors.
   assign size_ok   = (size <= 3'd3);
   assign next_addr = size_ok ? (cur_addr + (ADDR_W'(1) << size)) : cur_addr;
   assign next_err  = (next_addr > MAX_ADDR);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (ar_hs) begin
               state_nxt = ar_err ? ERR : ISSUE;
            end
         end
         ISSUE: begin
            if (mem_ack) begin
               state_nxt = RESP;
            end
         end
         ERR: begin
            state_nxt = RESP;
         end
         RESP: begin
            if (r_hs) begin
               if (rlast) begin
                  state_nxt = IDLE;
               end else if (sticky_err | next_err) begin
                  state_nxt = ERR;
               end else begin
                  state_nxt = ISSUE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_addr   <= '0;
         len        <= '0;
         size       <= '0;
         rid        <= '0;
         beat_cnt   <= '0;
         sticky_err <= 1'b0;
         rvalid     <= 1'b0;
         rdata      <= '0;
         rresp      <= RESP_OKAY;
         rlast      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ar_hs) begin
                  cur_addr   <= araddr;
                  len        <= arlen;
                  size       <= arsize;
                  rid        <= arid;
                  beat_cnt   <= '0;
                  sticky_err <= ar_err;
               end
            end
            ISSUE: begin
               if (mem_ack) begin
                  rdata  <= mem_rdata;
                  rresp  <= RESP_OKAY;
                  rvalid <= 1'b1;
                  rlast  <= last_beat;
               end
            end
            ERR: begin
               rdata      <= '0;
               rresp      <= RESP_SLVERR;
               rvalid     <= 1'b1;
               rlast      <= last_beat;
               sticky_err <= 1'b1;
            end
            RESP: begin
               if (r_hs) begin
                  rvalid <= 1'b0;
                  if (!rlast) begin
                     beat_cnt   <= beat_cnt + 8'd1;
                     cur_addr   <= next_addr;
                     sticky_err <= sticky_err | next_err;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_read_burst_sequencer.sv
// Directed bench for axi_read_burst_sequencer with a fixed-latency memory responder.
`timescale 1ns/1ps
module tb_axi_read_burst_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] araddr = '0;
   logic [7:0]  arlen = '0;
   logic [2:0]  arsize = '0;
   logic [3:0]  arid = '0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [2:0]  mem_size;
   logic        mem_ack = 1'b0;
   logic [63:0] mem_rdata = '0;
   logic        rvalid;
   logic        rready = 1'b0;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic [3:0]  rid;
   logic        busy;

   int          checks = 0;
   int          errors = 0;
   logic        ack_en = 1'b1;
   int          wait_cnt = 0;
   logic [31:0] addr_log[$];

   always #5 clk = ~clk;

   axi_read_burst_sequencer #(
      .ADDR_W(32), .DATA_W(64), .ID_W(4), .MAX_ADDR(32'hFF)
   ) dut (
      .clk(clk), .rst(rst),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
      .arsize(arsize), .arid(arid),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_size(mem_size),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .rlast(rlast), .rid(rid), .busy(busy)
   );

   function automatic logic [63:0] mem_word(input logic [31:0] a);
      return 64'hC0DE_0000_0000_0000 | {32'h0, a};
   endfunction

   // Memory answers one cycle after it first sees a request.
   always @(negedge clk) begin
      if (mem_req && ack_en && !mem_ack) begin
         if (wait_cnt >= 1) begin
            mem_ack = 1'b1;
            mem_rdata = mem_word(mem_addr);
            addr_log.push_back(mem_addr);
            wait_cnt = 0;
         end else begin
            wait_cnt = wait_cnt + 1;
         end
      end else begin
         mem_ack = 1'b0;
         if (!mem_req) wait_cnt = 0;
      end
   end

   task automatic send_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [3:0] id, output bit to);
      int t = 0;
      @(negedge clk);
      arvalid = 1'b1; araddr = a; arlen = l; arsize = s; arid = id;
      while (!arready && t < 100) begin
         @(negedge clk);
         t++;
      end
      to = !arready;
      @(negedge clk);
      arvalid = 1'b0;
   endtask

   task automatic take_beat(output logic [63:0] d, output logic [1:0] rs, output logic lst,
                            output logic [3:0] id, output bit to);
      int t = 0;
      @(negedge clk);
      while (!rvalid && t < 100) begin
         @(negedge clk);
         t++;
      end
      to = !rvalid;
      d = rdata; rs = rresp; lst = rlast; id = rid;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({mem_req, rvalid, rdata, rresp, rlast, rid, busy, mem_addr, mem_size} !== 110'd0) begin
         errors++;
         $display("FAIL reset_outputs: got req=%b rvalid=%b rdata=%h rresp=%b rlast=%b rid=%h busy=%b addr=%h size=%0d, expected all 0",
                  mem_req, rvalid, rdata, rresp, rlast, rid, busy, mem_addr, mem_size);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({arready, busy} !== 2'b10) begin
         errors++;
         $display("FAIL reset_arready: got arready=%b busy=%b, expected 1 0", arready, busy);
      end
   endtask

   task automatic test_basic();
      logic [63:0] d; logic [1:0] rs; logic lst; logic [3:0] id; bit to;
      addr_log.delete();
      send_ar(32'h10, 8'd3, 3'd2, 4'd5, to);
      checks++;
      if ({to, mem_req, mem_addr, mem_size, arready, busy} !== {1'b0, 1'b1, 32'h10, 3'd2, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL basic_first_req: got to=%b req=%b addr=%h size=%0d arready=%b busy=%b, expected 0 1 10 2 0 1",
                  to, mem_req, mem_addr, mem_size, arready, busy);
      end
      for (int i = 0; i < 4; i++) begin
         logic [31:0] a;
         a = 32'h10 + 32'(4 * i);
         take_beat(d, rs, lst, id, to);
         checks++;
         if ({to, rs, lst, id, d} !== {1'b0, 2'b00, (i == 3), 4'd5, mem_word(a)}) begin
            errors++;
            $display("FAIL basic_beat%0d: got to=%b resp=%b last=%b id=%h data=%h, expected 0 00 %b 5 %h",
                     i, to, rs, lst, id, d, (i == 3), mem_word(a));
         end
         if (i < 3) begin
            checks++;
            if ({mem_req, mem_addr} !== {1'b1, a + 32'd4}) begin
               errors++;
               $display("FAIL basic_next_req%0d: got req=%b addr=%h, expected 1 %h", i, mem_req, mem_addr, a + 32'd4);
            end
         end
      end
      checks++;
      if (addr_log.size() != 4 || addr_log[0] !== 32'h10 || addr_log[1] !== 32'h14 ||
          addr_log[2] !== 32'h18 || addr_log[3] !== 32'h1C || arready !== 1'b1) begin
         errors++;
         $display("FAIL basic_addr_log: got %0d reqs, arready=%b, expected 10,14,18,1C and arready 1",
                  addr_log.size(), arready);
      end
   endtask

   task automatic test_range_err();
      logic [63:0] d; logic [1:0] rs; logic lst; logic [3:0] id; bit to;
      addr_log.delete();
      send_ar(32'hF8, 8'd3, 3'd3, 4'd2, to);
      for (int i = 0; i < 4; i++) begin
         logic [63:0] ed;
         logic [1:0]  er;
         ed = (i == 0) ? mem_word(32'hF8) : 64'd0;
         er = (i == 0) ? 2'b00 : 2'b10;
         take_beat(d, rs, lst, id, to);
         checks++;
         if ({to, rs, lst, id, d} !== {1'b0, er, (i == 3), 4'd2, ed}) begin
            errors++;
            $display("FAIL range_beat%0d: got to=%b resp=%b last=%b id=%h data=%h, expected 0 %b %b 2 %h",
                     i, to, rs, lst, id, d, er, (i == 3), ed);
         end
         if (i == 0) begin
            checks++;
            if (mem_req !== 1'b0) begin
               errors++;
               $display("FAIL range_no_req: got mem_req=%b, expected 0", mem_req);
            end
         end
      end
      checks++;
      if (addr_log.size() != 1 || addr_log[0] !== 32'hF8) begin
         errors++;
         $display("FAIL range_addr_log: got %0d reqs, expected 1 at F8", addr_log.size());
      end
   endtask

   task automatic test_bad_size();
      logic [63:0] d; logic [1:0] rs; logic lst; logic [3:0] id; bit to;
      addr_log.delete();
      send_ar(32'h20, 8'd1, 3'd5, 4'd7, to);
      checks++;
      if ({to, mem_req, busy, arready} !== 4'b0010) begin
         errors++;
         $display("FAIL size_start: got to=%b req=%b busy=%b arready=%b, expected 0 0 1 0", to, mem_req, busy, arready);
      end
      for (int i = 0; i < 2; i++) begin
         take_beat(d, rs, lst, id, to);
         checks++;
         if ({to, rs, lst, id, d} !== {1'b0, 2'b10, (i == 1), 4'd7, 64'd0}) begin
            errors++;
            $display("FAIL size_beat%0d: got to=%b resp=%b last=%b id=%h data=%h, expected 0 10 %b 7 0",
                     i, to, rs, lst, id, d, (i == 1));
         end
         if (i == 0) begin
            checks++;
            if ({mem_addr, arready} !== {32'h20, 1'b0}) begin
               errors++;
               $display("FAIL size_addr_hold: got addr=%h arready=%b, expected 20 0", mem_addr, arready);
            end
         end
      end
      checks++;
      if (arready !== 1'b1 || addr_log.size() != 0) begin
         errors++;
         $display("FAIL size_end: got arready=%b reqs=%0d, expected 1 0", arready, addr_log.size());
      end
   endtask

   task automatic test_stall();
      logic [63:0] d; logic [1:0] rs; logic lst; logic [3:0] id; bit to;
      int t = 0;
      send_ar(32'h40, 8'd2, 3'd1, 4'd3, to);
      take_beat(d, rs, lst, id, to);
      @(negedge clk);
      while (!rvalid && t < 100) begin
         @(negedge clk);
         t++;
      end
      d = rdata; rs = rresp; lst = rlast;
      checks++;
      if ({rvalid, rs, lst, d} !== {1'b1, 2'b00, 1'b0, mem_word(32'h42)}) begin
         errors++;
         $display("FAIL stall_beat1: got rvalid=%b resp=%b last=%b data=%h, expected 1 00 0 %h",
                  rvalid, rs, lst, d, mem_word(32'h42));
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if ({rvalid, rdata, rresp, rlast, mem_req} !== {1'b1, mem_word(32'h42), 2'b00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL stall_hold%0d: got rvalid=%b data=%h resp=%b last=%b req=%b, expected 1 %h 00 0 0",
                     k, rvalid, rdata, rresp, rlast, mem_req, mem_word(32'h42));
         end
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      checks++;
      if ({mem_req, mem_addr} !== {1'b1, 32'h44}) begin
         errors++;
         $display("FAIL stall_release: got req=%b addr=%h, expected 1 44", mem_req, mem_addr);
      end
      take_beat(d, rs, lst, id, to);
      checks++;
      if ({to, rs, lst, id, d} !== {1'b0, 2'b00, 1'b1, 4'd3, mem_word(32'h44)}) begin
         errors++;
         $display("FAIL stall_last: got to=%b resp=%b last=%b id=%h data=%h, expected 0 00 1 3 %h",
                  to, rs, lst, id, d, mem_word(32'h44));
      end
   endtask

   task automatic test_mid_reset();
      logic [63:0] d; logic [1:0] rs; logic lst; logic [3:0] id; bit to;
      ack_en = 1'b0;
      send_ar(32'h80, 8'd3, 3'd2, 4'd9, to);
      checks++;
      if ({to, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h80}) begin
         errors++;
         $display("FAIL rst_pre: got to=%b req=%b addr=%h, expected 0 1 80", to, mem_req, mem_addr);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({mem_req, rvalid, rdata, rresp, rlast, rid, busy, arready, mem_addr, mem_size} !== {110'd0, 1'b1, 35'd0}) begin
         errors++;
         $display("FAIL rst_mid: got req=%b rvalid=%b rdata=%h rresp=%b rlast=%b rid=%h busy=%b arready=%b addr=%h size=%0d, expected 0s and arready 1",
                  mem_req, rvalid, rdata, rresp, rlast, rid, busy, arready, mem_addr, mem_size);
      end
      rst = 1'b0;
      ack_en = 1'b1;
      send_ar(32'h08, 8'd0, 3'd0, 4'hA, to);
      take_beat(d, rs, lst, id, to);
      checks++;
      if ({to, rs, lst, id, d, arready} !== {1'b0, 2'b00, 1'b1, 4'hA, mem_word(32'h08), 1'b1}) begin
         errors++;
         $display("FAIL rst_after: got to=%b resp=%b last=%b id=%h data=%h arready=%b, expected 0 00 1 a %h 1",
                  to, rs, lst, id, d, arready, mem_word(32'h08));
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] d; logic [1:0] rs; logic lst; logic [3:0] id; bit to;
      int t = 0;
      send_ar(32'h00, 8'd0, 3'd0, 4'd1, to);
      while (!rvalid && t < 100) begin
         @(negedge clk);
         t++;
      end
      arvalid = 1'b1; araddr = 32'h30; arlen = 8'd0; arsize = 3'd0; arid = 4'd2;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++;
         if ({arready, rvalid, busy} !== 3'b011) begin
            errors++;
            $display("FAIL b2b_blocked%0d: got arready=%b rvalid=%b busy=%b, expected 0 1 1", k, arready, rvalid, busy);
         end
      end
      checks++;
      if ({rresp, rlast, rid, rdata} !== {2'b00, 1'b1, 4'd1, mem_word(32'h00)}) begin
         errors++;
         $display("FAIL b2b_first: got resp=%b last=%b id=%h data=%h, expected 00 1 1 %h",
                  rresp, rlast, rid, rdata, mem_word(32'h00));
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      checks++;
      if (arready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_idle: got arready=%b, expected 1", arready);
      end
      @(negedge clk);
      arvalid = 1'b0;
      checks++;
      if ({mem_req, mem_addr, busy} !== {1'b1, 32'h30, 1'b1}) begin
         errors++;
         $display("FAIL b2b_second_req: got req=%b addr=%h busy=%b, expected 1 30 1", mem_req, mem_addr, busy);
      end
      take_beat(d, rs, lst, id, to);
      checks++;
      if ({to, rs, lst, id, d} !== {1'b0, 2'b00, 1'b1, 4'd2, mem_word(32'h30)}) begin
         errors++;
         $display("FAIL b2b_second: got to=%b resp=%b last=%b id=%h data=%h, expected 0 00 1 2 %h",
                  to, rs, lst, id, d, mem_word(32'h30));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_range_err();
      test_bad_size();
      test_stall();
      test_mid_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

endmodule
